// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: MDU opcode encodings,
// the latency counter width and the wrapper FSM state type.
package mdu_pkg;

  localparam int unsigned CNT_W = 4;

  localparam logic [3:0] MD_OP_NONE  = 4'd0;
  localparam logic [3:0] MD_OP_MULT  = 4'd1;
  localparam logic [3:0] MD_OP_MULTU = 4'd2;
  localparam logic [3:0] MD_OP_DIV   = 4'd3;
  localparam logic [3:0] MD_OP_DIVU  = 4'd4;
  localparam logic [3:0] MD_OP_MTHI  = 4'd5;
  localparam logic [3:0] MD_OP_MTLO  = 4'd6;
  localparam logic [3:0] MD_OP_MADD  = 4'd7;
  localparam logic [3:0] MD_OP_MADDU = 4'd8;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } mdu_state_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// E-stage MDU command / read-back bundle.
//   md_valid, md_op, req, src_a, src_b, rd_sel : pipeline -> MDU
//   busy, hi_lo_out                             : MDU -> pipeline
// master = pipeline/hazard side, slave = mul_div_unit.
interface mul_div_unit_if;
  logic        md_valid;
  logic [3:0]  md_op;
  logic        req;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        rd_sel;
  logic        busy;
  logic [31:0] hi_lo_out;

  modport master (
    output md_valid, md_op, req, src_a, src_b, rd_sel,
    input  busy, hi_lo_out
  );

  modport slave (
    input  md_valid, md_op, req, src_a, src_b, rd_sel,
    output busy, hi_lo_out
  );
endinterface

// File: rtl/mdu_core.sv
// Combinational datapath of the MDU: 64-bit product, quotient/remainder and
// (with MDU_MADD_EN defined) multiply-accumulate onto the current HI/LO.
// Ports:
//   op       : MDU opcode
//   src_a/b  : operands (rs, rt)
//   hi/lo    : current architectural HI/LO (accumulate source)
//   arith    : op is a multi-cycle arithmetic op
//   is_div   : op uses the divide latency
//   wr_en    : result should be committed (low on divide by zero)
//   result   : {HI, LO} to commit
// Optional feature macro: MDU_MADD_EN (enables madd/maddu).
module mdu_core
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic        arith,
  output logic        is_div,
  output logic        wr_en,
  output logic [63:0] result
);

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, div_b, q_mag, r_mag;
  logic        sgn_div, neg_q, neg_r;

`ifndef MDU_MADD_EN
  logic unused_hilo;
  assign unused_hilo = ^{hi, lo};
`endif

  always_comb begin
    prod_u = {32'd0, src_a} * {32'd0, src_b};
    // Low 64 bits of the sign-extended product equal the signed product.
    prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};

    // Signed divide runs on magnitudes; |0x80000000| as unsigned is exact.
    sgn_div = (op == MD_OP_DIV);
    a_mag   = (sgn_div && src_a[31]) ? -src_a : src_a;
    b_mag   = (sgn_div && src_b[31]) ? -src_b : src_b;
    div_b   = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag   = a_mag / div_b;
    r_mag   = a_mag % div_b;
    neg_q   = sgn_div && (src_a[31] ^ src_b[31]);
    neg_r   = sgn_div && src_a[31];

    arith  = 1'b0;
    is_div = 1'b0;
    wr_en  = 1'b1;
    result = 64'd0;
    case (op)
      MD_OP_MULT: begin
        arith  = 1'b1;
        result = prod_s;
      end
      MD_OP_MULTU: begin
        arith  = 1'b1;
        result = prod_u;
      end
      MD_OP_DIV, MD_OP_DIVU: begin
        arith  = 1'b1;
        is_div = 1'b1;
        wr_en  = (src_b != 32'd0);
        result = {neg_r ? -r_mag : r_mag, neg_q ? -q_mag : q_mag};
      end
`ifdef MDU_MADD_EN
      MD_OP_MADD: begin
        arith  = 1'b1;
        result = {hi, lo} + prod_s;
      end
      MD_OP_MADDU: begin
        arith  = 1'b1;
        result = {hi, lo} + prod_u;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// E-stage multiply/divide unit. Owns HI/LO, runs arithmetic ops with a fixed
// busy latency and commits the latched result when the counter expires.
// Ports:
//   clk   : pipeline clock, rising edge
//   reset : synchronous active-high reset
//   bus   : mul_div_unit_if slave (command, operands, rd_sel, busy, hi_lo_out)
// Parameters: MULT_CYCLES, DIV_CYCLES (1..15) busy durations.
// Optional feature macro: MDU_MADD_EN (madd/maddu, decoded in mdu_core).
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic           clk,
  input logic           reset,
  mul_div_unit_if.slave bus
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [63:0]      shadow_q, shadow_d;
  logic             shadow_we_q, shadow_we_d;

  logic        arith, is_div, wr_en, cmd;
  logic [63:0] result;

  mdu_core u_core (
    .op     (bus.md_op),
    .src_a  (bus.src_a),
    .src_b  (bus.src_b),
    .hi     (hi_q),
    .lo     (lo_q),
    .arith  (arith),
    .is_div (is_div),
    .wr_en  (wr_en),
    .result (result)
  );

  assign cmd = bus.md_valid & ~bus.req & (state_q == StIdle);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    shadow_d    = shadow_q;
    shadow_we_d = shadow_we_q;
    case (state_q)
      StIdle: begin
        if (cmd) begin
          if (bus.md_op == MD_OP_MTHI) begin
            hi_d = bus.src_a;
          end else if (bus.md_op == MD_OP_MTLO) begin
            lo_d = bus.src_a;
          end else if (arith) begin
            shadow_d    = result;
            shadow_we_d = wr_en;
            cnt_d       = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            state_d     = StBusy;
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = StIdle;
          if (shadow_we_q) begin
            {hi_d, lo_d} = shadow_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      shadow_q    <= '0;
      shadow_we_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      shadow_q    <= shadow_d;
      shadow_we_q <= shadow_we_d;
    end
  end

  assign bus.busy      = (state_q == StBusy);
  assign bus.hi_lo_out = bus.rd_sel ? lo_q : hi_q;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  // Reference HI/LO state.
  logic [31:0] hi_m, lo_m;

  mul_div_unit_if bus ();

  mul_div_unit #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic int exp_lat(input logic [3:0] op);
    case (op)
      4'd1, 4'd2: return MULT_N;
      4'd3, 4'd4: return DIV_N;
`ifdef MDU_MADD_EN
      4'd7, 4'd8: return MULT_N;
`endif
      default: return 0;
    endcase
  endfunction

  task automatic model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p, acc, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      4'd1: begin p = sa * sb; hi_m = p[63:32]; lo_m = p[31:0]; end
      4'd2: begin p = ua * ub; hi_m = p[63:32]; lo_m = p[31:0]; end
      4'd3: if (b != 0) begin
        q = sa / sb; r = sa % sb;
        lo_m = q[31:0]; hi_m = r[31:0];
      end
      4'd4: if (b != 0) begin
        p = ua / ub; acc = ua % ub;
        lo_m = p[31:0]; hi_m = acc[31:0];
      end
      4'd5: hi_m = a;
      4'd6: lo_m = a;
`ifdef MDU_MADD_EN
      4'd7: begin p = sa * sb; acc = {hi_m, lo_m} + p; hi_m = acc[63:32]; lo_m = acc[31:0]; end
      4'd8: begin p = ua * ub; acc = {hi_m, lo_m} + p; hi_m = acc[63:32]; lo_m = acc[31:0]; end
`endif
      default: ;
    endcase
  endtask

  // Drives one command for one cycle; returns in cycle T+1 (at a negedge).
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic rq);
    @(negedge clk);
    bus.md_valid = 1'b1; bus.md_op = op; bus.src_a = a; bus.src_b = b; bus.req = rq;
    @(negedge clk);
    bus.md_valid = 1'b0; bus.md_op = 4'd0; bus.req = 1'b0;
  endtask

  // Counts busy cycles from the current negedge, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    bus.rd_sel = 1'b0; #1 h = bus.hi_lo_out;
    bus.rd_sel = 1'b1; #1 l = bus.hi_lo_out;
    bus.rd_sel = 1'b0; #1;
  endtask

  task automatic test_reset;
    logic [31:0] h, l;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    hi_m = 0; lo_m = 0;
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy got %b want 0", bus.busy);
    end
    read_hilo(h, l);
    vectors++;
    if (h !== 32'd0 || l !== 32'd0) begin
      miscompares++; $display("FAIL reset_hilo got %h/%h want 0/0", h, l);
    end
  endtask

  task automatic test_mult;
    int n; logic [31:0] h, l;
    issue(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    wait_idle(n); model_apply(4'd1, 32'hFFFF_FFFE, 32'd3);
    read_hilo(h, l);
    vectors++;
    if (n != MULT_N) begin miscompares++; $display("FAIL mult_busy got %0d want %0d", n, MULT_N); end
    vectors++;
    if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFA) begin
      miscompares++; $display("FAIL mult_result got %h/%h want ffffffff/fffffffa", h, l);
    end
    issue(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
    wait_idle(n); model_apply(4'd2, 32'hFFFF_FFFE, 32'd3);
    read_hilo(h, l);
    vectors++;
    if (h !== 32'h0000_0002 || l !== 32'hFFFF_FFFA) begin
      miscompares++; $display("FAIL multu_result got %h/%h want 00000002/fffffffa", h, l);
    end
  endtask

  task automatic test_div;
    int n; logic [31:0] h, l;
    issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle(n); model_apply(4'd3, 32'hFFFF_FFF9, 32'd2);
    read_hilo(h, l);
    vectors++;
    if (n != DIV_N) begin miscompares++; $display("FAIL div_busy got %0d want %0d", n, DIV_N); end
    vectors++;
    if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFD) begin
      miscompares++; $display("FAIL div_result got %h/%h want ffffffff/fffffffd", h, l);
    end
    issue(4'd4, 32'd7, 32'd0, 1'b0);
    wait_idle(n);
    read_hilo(h, l);
    vectors++;
    if (n != DIV_N) begin miscompares++; $display("FAIL divu0_busy got %0d want %0d", n, DIV_N); end
    vectors++;
    if (h !== hi_m || l !== lo_m) begin
      miscompares++; $display("FAIL divu0_hilo got %h/%h want %h/%h", h, l, hi_m, lo_m);
    end
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle(n);
    read_hilo(h, l);
    vectors++;
    if (h !== 32'd0 || l !== 32'h8000_0000) begin
      miscompares++; $display("FAIL div_ovf got %h/%h want 00000000/80000000", h, l);
    end
    hi_m = h == 32'd0 ? 32'd0 : 32'd0; lo_m = 32'h8000_0000;
  endtask

  task automatic test_mt;
    logic [31:0] h, l;
    issue(4'd6, 32'h1234_5678, 32'd0, 1'b0);
    model_apply(4'd6, 32'h1234_5678, 32'd0);
    bus.rd_sel = 1'b1; #1;
    vectors++;
    if (bus.hi_lo_out !== 32'h1234_5678 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mtlo got %h busy %b want 12345678 busy 0", bus.hi_lo_out, bus.busy);
    end
    bus.rd_sel = 1'b0;
    issue(4'd5, 32'hCAFE_F00D, 32'd0, 1'b0);
    model_apply(4'd5, 32'hCAFE_F00D, 32'd0);
    read_hilo(h, l);
    vectors++;
    if (h !== 32'hCAFE_F00D || l !== 32'h1234_5678 || bus.busy !== 1'b0) begin
      miscompares++; $display("FAIL mthi got %h/%h want cafef00d/12345678", h, l);
    end
  endtask

  task automatic test_req_and_ignore;
    int n; logic [31:0] h, l;
    issue(4'd1, 32'd100, 32'd100, 1'b1);
    wait_idle(n);
    read_hilo(h, l);
    vectors++;
    if (n != 0 || h !== hi_m || l !== lo_m) begin
      miscompares++; $display("FAIL req_cancel got busy %0d %h/%h want 0 %h/%h", n, h, l, hi_m, lo_m);
    end
    issue(4'd2, 32'd6, 32'd7, 1'b0);
    model_apply(4'd2, 32'd6, 32'd7);
    // Second command lands in cycle T+1 while busy.
    bus.md_valid = 1'b1; bus.md_op = 4'd1; bus.src_a = 32'd9; bus.src_b = 32'd9;
    @(negedge clk);
    bus.md_valid = 1'b0; bus.md_op = 4'd0;
    wait_idle(n);
    read_hilo(h, l);
    vectors++;
    if (n != MULT_N - 1 || h !== 32'd0 || l !== 32'd42) begin
      miscompares++; $display("FAIL busy_ignore got rem %0d %h/%h want %0d 0/2a", n, h, l, MULT_N - 1);
    end
  endtask

  task automatic test_reset_mid;
    int n; logic [31:0] h, l;
    issue(4'd4, 32'd1000, 32'd3, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hi_m = 0; lo_m = 0;
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy got %b want 0", bus.busy); end
    repeat (DIV_N + 2) @(negedge clk);
    read_hilo(h, l);
    vectors++;
    if (h !== 32'd0 || l !== 32'd0 || bus.busy !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid_hilo got %h/%h want 0/0", h, l);
    end
  endtask

  task automatic test_madd;
    int n; logic [31:0] h, l;
    issue(4'd5, 32'd0, 32'd0, 1'b0);
    issue(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0);
    model_apply(4'd5, 32'd0, 32'd0);
    model_apply(4'd6, 32'hFFFF_FFFF, 32'd0);
    issue(4'd7, 32'd1, 32'd1, 1'b0);
    wait_idle(n);
    read_hilo(h, l);
    model_apply(4'd7, 32'd1, 32'd1);
    vectors++;
`ifdef MDU_MADD_EN
    if (n != MULT_N || h !== 32'd1 || l !== 32'd0) begin
      miscompares++; $display("FAIL madd got busy %0d %h/%h want %0d 1/0", n, h, l, MULT_N);
    end
`else
    if (n != 0 || h !== 32'd0 || l !== 32'hFFFF_FFFF) begin
      miscompares++; $display("FAIL madd_off got busy %0d %h/%h want 0 0/ffffffff", n, h, l);
    end
`endif
  endtask

  task automatic test_random;
    int n, lat;
    logic [3:0]  op;
    logic [31:0] a, b, h, l, prev_hi;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 9));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 9) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
      lat = exp_lat(op);
      prev_hi = hi_m;
      issue(op, a, b, 1'b0);
      if (lat > 0) begin
        #1;
        vectors++;
        if (bus.hi_lo_out !== prev_hi) begin
          miscompares++; $display("FAIL rnd%0d_shadow got %h want %h", i, bus.hi_lo_out, prev_hi);
        end
      end
      wait_idle(n);
      model_apply(op, a, b);
      read_hilo(h, l);
      vectors++;
      if (n != lat || h !== hi_m || l !== lo_m) begin
        miscompares++;
        $display("FAIL rnd%0d op %0d a %h b %h got busy %0d %h/%h want %0d %h/%h",
                 i, op, a, b, n, h, l, lat, hi_m, lo_m);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.md_valid = 1'b0; bus.md_op = 4'd0; bus.req = 1'b0;
    bus.src_a = 32'd0; bus.src_b = 32'd0; bus.rd_sel = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_mt();
    test_req_and_ignore();
    test_reset_mid();
    test_madd();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
